// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants, state encoding and helpers for the load/store stage
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [3:0] WMASK_B = 4'b0001;
    localparam logic [3:0] WMASK_H = 4'b0011;
    localparam logic [3:0] WMASK_W = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        WB   = 2'd3
    } lsu_state_e;

    function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B:    store_mask = WMASK_B << off;
            F3_H:    store_mask = WMASK_H << off;
            default: store_mask = WMASK_W;
        endcase
    endfunction

    // Width code, exclusivity of load/store and natural alignment all have to hold.
    function automatic logic op_legal(input logic ld, input logic st,
                                      input logic [2:0] f3, input logic [1:0] off);
        logic f3_ok;
        logic align_ok;
        if (ld)
            f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                    (f3 == F3_BU) || (f3 == F3_HU);
        else
            f3_ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        case (f3)
            F3_H, F3_HU: align_ok = ~off[0];
            F3_W:        align_ok = (off == 2'b00);
            default:     align_ok = 1'b1;
        endcase
        op_legal = (ld ^ st) && f3_ok && align_ok;
    endfunction

endpackage

// File: rtl/lsu_wb_if.sv
// rtl/lsu_wb_if.sv - word-wide memory request/response bus of the load/store stage
interface lsu_wb_if #(
    parameter int XLEN = 32
);
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_addr;
    logic            mem_wen;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_wmask;
    logic            mem_resp_valid;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - byte/half/word lane extraction with sign or zero extension
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    // Word loads are always aligned, so the shifted value is the raw word.
    always_comb begin
        result = shifted;
        case (funct3)
            F3_B:    result = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_BU:   result = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_H:    result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_HU:   result = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_wb.sv
// rtl/lsu_wb.sv - single-outstanding load/store stage with register-file writeback
module lsu_wb
    import lsu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  is_load,
    input  logic                  is_store,
    input  logic [2:0]            funct3,
    input  logic [XLEN-1:0]       base,
    input  logic [XLEN-1:0]       sdata,
    input  logic [XLEN-1:0]       imm,
    input  logic [ADDR_WIDTH-1:0] rd,
    lsu_wb_if.master              mem,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_rd,
    output logic [XLEN-1:0]       rf_dataD,
    output logic                  done,
    output logic                  err
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_REQ  = REQ;
    localparam logic [1:0] ST_WAIT = WAIT;
    localparam logic [1:0] ST_WB   = WB;

    logic [1:0]            state;
    logic [XLEN-1:0]       ea_q;
    logic [XLEN-1:0]       sdata_q;
    logic [XLEN-1:0]       load_q;
    logic [2:0]            f3_q;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic                  is_store_q;
    logic                  err_q;

    logic [XLEN-1:0]       ea_in;
    logic                  accept;
    logic                  legal;
    logic [XLEN-1:0]       align_out;
    logic                  in_req;
    logic                  in_wb;
    logic                  st_req;

    assign ea_in  = base + imm;
    assign accept = in_valid && (state == ST_IDLE) && (is_load || is_store);
    assign legal  = op_legal(is_load, is_store, funct3, ea_in[1:0]);

    lsu_load_align #(.XLEN(XLEN)) u_load_align (
        .rdata  (mem.mem_rdata),
        .offset (ea_q[1:0]),
        .funct3 (f3_q),
        .result (align_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ea_q       <= '0;
            sdata_q    <= '0;
            load_q     <= '0;
            f3_q       <= '0;
            rd_q       <= '0;
            is_store_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= accept && !legal;
            case (state)
                ST_IDLE: begin
                    if (accept && legal) begin
                        state      <= ST_REQ;
                        ea_q       <= ea_in;
                        sdata_q    <= sdata;
                        f3_q       <= funct3;
                        rd_q       <= rd;
                        is_store_q <= is_store;
                    end
                end
                ST_REQ: begin
                    if (mem.mem_req_ready)
                        state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem.mem_resp_valid) begin
                        state <= ST_WB;
                        if (!is_store_q)
                            load_q <= align_out;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Request fields come only from latched state, so they stay put across a stall.
    assign in_req = (state == ST_REQ);
    assign in_wb  = (state == ST_WB);
    assign st_req = in_req && is_store_q;

    assign in_ready          = (state == ST_IDLE);
    assign mem.mem_req_valid = in_req;
    assign mem.mem_addr      = in_req ? {ea_q[XLEN-1:2], 2'b00} : '0;
    assign mem.mem_wen       = st_req;
    assign mem.mem_wdata     = st_req ? (sdata_q << {ea_q[1:0], 3'b000}) : '0;
    assign mem.mem_wmask     = st_req ? store_mask(f3_q, ea_q[1:0]) : 4'b0000;

    assign rf_wen   = in_wb && !is_store_q && (rd_q != '0);
    assign rf_rd    = rf_wen ? rd_q : '0;
    assign rf_dataD = rf_wen ? load_q : '0;
    assign done     = in_wb || err_q;
    assign err      = err_q;

endmodule

// File: tb/tb_lsu_wb.sv
// tb/tb_lsu_wb.sv - directed self-checking bench for lsu_wb
module tb_lsu_wb;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] base;
    logic [31:0] sdata;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rf_wen;
    logic [4:0]  rf_rd;
    logic [31:0] rf_dataD;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lsu_wb_if #(.XLEN(32)) mem_bus ();

    lsu_wb #(.XLEN(32), .ADDR_WIDTH(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .is_load  (is_load),
        .is_store (is_store),
        .funct3   (funct3),
        .base     (base),
        .sdata    (sdata),
        .imm      (imm),
        .rd       (rd),
        .mem      (mem_bus),
        .rf_wen   (rf_wen),
        .rf_rd    (rf_rd),
        .rf_dataD (rf_dataD),
        .done     (done),
        .err      (err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] b, input logic [31:0] i,
                         input logic [31:0] sd, input logic [4:0] r);
        in_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3;
        base = b; imm = i; sdata = sd; rd = r;
        step();
        in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
        base = $urandom; imm = $urandom; sdata = $urandom; rd = 5'($urandom);
    endtask

    task automatic run_op(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] b, input logic [31:0] i, input logic [31:0] sd,
                          input logic [4:0] r, input logic [31:0] rdata,
                          input int req_dly, input int resp_dly, input logic junk,
                          input logic [31:0] e_addr, input logic [31:0] e_wdata,
                          input logic [3:0] e_wmask, input logic e_rfwen, input logic [31:0] e_data);
        check_eq({tag, " in_ready before"}, 32'(in_ready), 32'd1);
        issue(ld, st, f3, b, i, sd, r);
        for (int k = 0; k <= req_dly; k++) begin
            mem_bus.mem_req_ready  = (k == req_dly);
            mem_bus.mem_resp_valid = junk;
            mem_bus.mem_rdata      = 32'h5555_5555;
            check_eq({tag, " req_valid"}, 32'(mem_bus.mem_req_valid), 32'd1);
            check_eq({tag, " addr"}, mem_bus.mem_addr, e_addr);
            check_eq({tag, " wen"}, 32'(mem_bus.mem_wen), 32'(st));
            check_eq({tag, " wdata"}, mem_bus.mem_wdata, e_wdata);
            check_eq({tag, " wmask"}, 32'(mem_bus.mem_wmask), 32'(e_wmask));
            check_eq({tag, " in_ready req"}, 32'(in_ready), 32'd0);
            step();
        end
        mem_bus.mem_req_ready  = 1'b0;
        for (int k = 0; k <= resp_dly; k++) begin
            mem_bus.mem_resp_valid = (k == resp_dly);
            mem_bus.mem_rdata      = (k == resp_dly) ? rdata : 32'hA5A5_A5A5;
            check_eq({tag, " req_valid wait"}, 32'(mem_bus.mem_req_valid), 32'd0);
            check_eq({tag, " rf_wen wait"}, 32'(rf_wen), 32'd0);
            check_eq({tag, " done wait"}, 32'(done), 32'd0);
            step();
        end
        mem_bus.mem_resp_valid = 1'b0;
        mem_bus.mem_rdata      = 32'h0;
        check_eq({tag, " done wb"}, 32'(done), 32'd1);
        check_eq({tag, " err wb"}, 32'(err), 32'd0);
        check_eq({tag, " rf_wen wb"}, 32'(rf_wen), 32'(e_rfwen));
        if (e_rfwen) begin
            check_eq({tag, " rf_rd"}, 32'(rf_rd), 32'(r));
            check_eq({tag, " rf_dataD"}, rf_dataD, e_data);
        end
        check_eq({tag, " in_ready wb"}, 32'(in_ready), 32'd0);
        step();
        check_eq({tag, " done after"}, 32'(done), 32'd0);
        check_eq({tag, " rf_wen after"}, 32'(rf_wen), 32'd0);
        check_eq({tag, " in_ready after"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_illegal(input string tag, input logic ld, input logic st,
                               input logic [2:0] f3, input logic [31:0] b, input logic [31:0] i);
        issue(ld, st, f3, b, i, 32'h0, 5'd3);
        check_eq({tag, " err"}, 32'(err), 32'd1);
        check_eq({tag, " done"}, 32'(done), 32'd1);
        check_eq({tag, " req_valid"}, 32'(mem_bus.mem_req_valid), 32'd0);
        check_eq({tag, " in_ready"}, 32'(in_ready), 32'd1);
        check_eq({tag, " rf_wen"}, 32'(rf_wen), 32'd0);
        step();
        check_eq({tag, " err clear"}, 32'(err), 32'd0);
        check_eq({tag, " done clear"}, 32'(done), 32'd0);
        check_eq({tag, " req_valid later"}, 32'(mem_bus.mem_req_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'd0;
        base = 32'h0; sdata = 32'h0; imm = 32'h0; rd = 5'd0;
        mem_bus.mem_req_ready = 1'b0; mem_bus.mem_resp_valid = 1'b0; mem_bus.mem_rdata = 32'h0;
        step(); step();
        rst = 1'b0;
        check_eq("rst in_ready", 32'(in_ready), 32'd1);
        check_eq("rst req_valid", 32'(mem_bus.mem_req_valid), 32'd0);
        check_eq("rst addr", mem_bus.mem_addr, 32'h0);
        check_eq("rst wen", 32'(mem_bus.mem_wen), 32'd0);
        check_eq("rst wdata", mem_bus.mem_wdata, 32'h0);
        check_eq("rst wmask", 32'(mem_bus.mem_wmask), 32'd0);
        check_eq("rst rf_wen", 32'(rf_wen), 32'd0);
        check_eq("rst rf_rd", 32'(rf_rd), 32'd0);
        check_eq("rst rf_dataD", rf_dataD, 32'h0);
        check_eq("rst done", 32'(done), 32'd0);
        check_eq("rst err", 32'(err), 32'd0);

        run_op("lw", 1, 0, F3_W, 32'h8000_0000, 32'h8, 32'h0, 5'd5, 32'hDEAD_BEEF,
               0, 0, 0, 32'h8000_0008, 32'h0, 4'b0000, 1, 32'hDEAD_BEEF);
        run_op("lb", 1, 0, F3_B, 32'h8000_0000, 32'h3, 32'h0, 5'd6, 32'h80FF_0011,
               0, 0, 0, 32'h8000_0000, 32'h0, 4'b0000, 1, 32'hFFFF_FF80);
        run_op("lbu", 1, 0, F3_BU, 32'h8000_0000, 32'h3, 32'h0, 5'd6, 32'h80FF_0011,
               0, 0, 0, 32'h8000_0000, 32'h0, 4'b0000, 1, 32'h0000_0080);
        run_op("lh hi", 1, 0, F3_H, 32'h200, 32'h2, 32'h0, 5'd8, 32'h8001_7FFF,
               0, 0, 0, 32'h200, 32'h0, 4'b0000, 1, 32'hFFFF_8001);
        run_op("lhu hi", 1, 0, F3_HU, 32'h200, 32'h2, 32'h0, 5'd8, 32'h8001_7FFF,
               0, 0, 0, 32'h200, 32'h0, 4'b0000, 1, 32'h0000_8001);
        run_op("lh lo", 1, 0, F3_H, 32'h200, 32'h0, 32'h0, 5'd9, 32'h8001_7FFF,
               0, 0, 0, 32'h200, 32'h0, 4'b0000, 1, 32'h0000_7FFF);
        run_op("sh", 0, 1, F3_H, 32'h100, 32'h2, 32'h1234_ABCD, 5'd3, 32'h0,
               0, 0, 0, 32'h100, 32'hABCD_0000, 4'b1100, 0, 32'h0);
        run_op("sb", 0, 1, F3_B, 32'h200, 32'h3, 32'h0000_00A5, 5'd3, 32'h0,
               0, 0, 0, 32'h200, 32'hA500_0000, 4'b1000, 0, 32'h0);
        run_op("sw", 0, 1, F3_W, 32'h300, 32'h0, 32'hCAFE_BABE, 5'd3, 32'h0,
               0, 0, 0, 32'h300, 32'hCAFE_BABE, 4'b1111, 0, 32'h0);
        run_op("lw stall", 1, 0, F3_W, 32'h200, 32'hFFFF_FFFC, 32'h0, 5'd7, 32'h0BAD_F00D,
               4, 3, 1, 32'h0000_01FC, 32'h0, 4'b0000, 1, 32'h0BAD_F00D);
        run_op("lw rd0", 1, 0, F3_W, 32'h40, 32'h4, 32'h0, 5'd0, 32'h1234_5678,
               0, 0, 0, 32'h44, 32'h0, 4'b0000, 0, 32'h0);

        run_illegal("ill lw mis", 1, 0, F3_W, 32'h100, 32'h2);
        run_illegal("ill sh mis", 0, 1, F3_H, 32'h100, 32'h1);
        run_illegal("ill ld f3", 1, 0, 3'd3, 32'h100, 32'h0);
        run_illegal("ill st f3", 0, 1, F3_BU, 32'h100, 32'h0);
        run_illegal("ill both", 1, 1, F3_W, 32'h100, 32'h0);

        in_valid = 1'b1; is_load = 1'b0; is_store = 1'b0; funct3 = F3_W;
        step();
        in_valid = 1'b0;
        check_eq("nop in_ready", 32'(in_ready), 32'd1);
        check_eq("nop req_valid", 32'(mem_bus.mem_req_valid), 32'd0);
        check_eq("nop done", 32'(done), 32'd0);
        check_eq("nop err", 32'(err), 32'd0);

        issue(1, 0, F3_W, 32'h400, 32'h0, 32'h0, 5'd9);
        mem_bus.mem_req_ready = 1'b1;
        step();
        mem_bus.mem_req_ready = 1'b0;
        check_eq("rstw in_ready wait", 32'(in_ready), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        mem_bus.mem_resp_valid = 1'b1;
        mem_bus.mem_rdata = 32'h1111_2222;
        check_eq("rstw in_ready", 32'(in_ready), 32'd1);
        check_eq("rstw rf_wen", 32'(rf_wen), 32'd0);
        check_eq("rstw done", 32'(done), 32'd0);
        check_eq("rstw req_valid", 32'(mem_bus.mem_req_valid), 32'd0);
        step();
        mem_bus.mem_resp_valid = 1'b0;
        check_eq("rstw rf_wen late", 32'(rf_wen), 32'd0);
        check_eq("rstw done late", 32'(done), 32'd0);
        check_eq("rstw in_ready late", 32'(in_ready), 32'd1);

        run_op("lw post rst", 1, 0, F3_W, 32'h500, 32'h10, 32'h0, 5'd11, 32'h7654_3210,
               1, 1, 0, 32'h510, 32'h0, 4'b0000, 1, 32'h7654_3210);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
